// File: rtl/j1_wb_pkg.sv
// Shared types and default constants for the J1-to-Wishbone sequencer.
package j1_wb_pkg;
  localparam int              AW_DEF       = 16;
  localparam int              DW_DEF       = 16;
  localparam logic [15:0]     ERR_DATA_DEF = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} seq_state_t;
endpackage

// File: rtl/wb_j1_watchdog.sv
// Counts wait cycles of an outstanding Wishbone transfer; flags expiry at TIMEOUT.
module wb_j1_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (run && count != LIMIT)
      count <= count + CW'(1);
  end

  // TIMEOUT of 0 keeps the counter at zero and never expires.
  assign expired = (TIMEOUT != 0) && run && (count == LIMIT);
endmodule

// File: rtl/wb_j1_sequencer.sv
// Serialises J1 data accesses and instruction fetches onto one Wishbone classic
// master port, stalling the core until the sequence completes.
module wb_j1_sequencer
  import j1_wb_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter int            TIMEOUT  = 15,
  parameter logic [DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ibus_re,
  input  logic [AW-1:0] ibus_adr,
  output logic [DW-1:0] ibus_dat,
  input  logic          dbus_re,
  input  logic          dbus_we,
  input  logic [AW-1:0] dbus_adr,
  input  logic [DW-1:0] dbus_dat_i,
  output logic [DW-1:0] dbus_dat_o,
  output logic          stall,
  output logic          bus_err,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [AW-1:0] wb_adr,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack
);
  seq_state_t    state, state_next;
  logic          pend_f, pend_d, we_l;
  logic [AW-1:0] dadr_l, iadr_l;
  logic [DW-1:0] wdat_l;
  logic          expired, xfer, req, run;
  logic [DW-1:0] rdata;

  assign req   = ibus_re | dbus_re | dbus_we;
  assign run   = (state == DATA) || (state == FETCH);
  assign xfer  = wb_ack | expired;
  assign rdata = wb_ack ? wb_dat_i : ERR_DATA;

  wb_j1_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state_next != state) | wb_ack),
    .run     (run),
    .expired (expired)
  );

  // NOTE: every output of this block is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    stall      = reset;
    wb_cyc     = 1'b0;
    wb_stb     = 1'b0;
    wb_we      = 1'b0;
    wb_adr     = '0;
    wb_dat_o   = '0;
    case (state)
      IDLE: begin
        if (req) begin
          stall      = 1'b1;
          state_next = (dbus_re | dbus_we) ? DATA : FETCH;
        end
      end
      DATA: begin
        stall    = 1'b1;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we_l;
        wb_adr   = dadr_l;
        wb_dat_o = we_l ? wdat_l : '0;
        if (xfer) state_next = pend_f ? FETCH : DONE;
      end
      FETCH: begin
        stall  = 1'b1;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_adr = iadr_l;
        if (xfer) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_f     <= 1'b0;
      pend_d     <= 1'b0;
      we_l       <= 1'b0;
      dadr_l     <= '0;
      iadr_l     <= '0;
      wdat_l     <= '0;
      ibus_dat   <= '0;
      dbus_dat_o <= '0;
      bus_err    <= 1'b0;
    end else begin
      state   <= state_next;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            pend_f <= ibus_re;
            pend_d <= dbus_re | dbus_we;
            we_l   <= dbus_we;
            dadr_l <= dbus_adr;
            iadr_l <= ibus_adr;
            wdat_l <= dbus_dat_i;
          end
        end
        DATA: begin
          if (xfer) begin
            if (!we_l) dbus_dat_o <= rdata;
            bus_err <= ~wb_ack;
            pend_d  <= 1'b0;
          end
        end
        FETCH: begin
          if (xfer) begin
            ibus_dat <= rdata;
            bus_err  <= ~wb_ack;
            pend_f   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
